// File: rtl/panel_pkg.sv
// Shared panel constants: pixel RAM geometry, SPI loader opcodes and the
// loader's FSM state encoding.
package panel_pkg;

    localparam int PIX_ADDR_WIDTH = 12;
    localparam int PIX_DATA_WIDTH = 16;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_FILL  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_FILL,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_pixel_writer_if.sv
// SPI pins in, pixel RAM write port and status out, plus the loader FSM state
// for observation.
interface spi_pixel_writer_if
    import panel_pkg::*;
#(
    parameter int ADDR_WIDTH = PIX_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIX_DATA_WIDTH
);
    logic                  i_spi_sck;
    logic                  i_spi_mosi;
    logic                  i_spi_cs_n;
    // o_ram_w_enable is a one-cycle strobe with no back-pressure: address and
    // data are valid exactly while it is high, and the RAM must accept it.
    logic [ADDR_WIDTH-1:0] o_ram_w_addr;
    logic [DATA_WIDTH-1:0] o_ram_w_data;
    logic                  o_ram_w_enable;
    logic                  o_busy;
    logic                  o_frame_done;
    state_t                o_dbg_state;

    modport slave (
        input  i_spi_sck, i_spi_mosi, i_spi_cs_n,
        output o_ram_w_addr, o_ram_w_data, o_ram_w_enable,
               o_busy, o_frame_done, o_dbg_state
    );

    modport master (
        output i_spi_sck, i_spi_mosi, i_spi_cs_n,
        input  o_ram_w_addr, o_ram_w_data, o_ram_w_enable,
               o_busy, o_frame_done, o_dbg_state
    );

endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the pins into i_clk, detects SCK
// rising edges and deserializes MSB-first bytes.
module spi_byte_rx (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spi_sck,
    input  logic       i_spi_mosi,
    input  logic       i_spi_cs_n,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_cs_active
);

    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       mosi_meta_q, mosi_sync_q;
    logic       cs_meta_q, cs_sync_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sck_rise;
    logic       byte_valid;

    assign sck_rise = sck_sync_q & ~sck_prev_q;

    // A deasserted chip select holds the counter so a partial byte is dropped.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_valid = 1'b0;
        if (cs_sync_q) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
            shift_d    = {shift_q[6:0], mosi_sync_q};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_valid = (bit_cnt_q == 3'd7);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
        end else begin
            sck_meta_q  <= i_spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= i_spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= i_spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign o_byte       = {shift_q[6:0], mosi_sync_q};
    assign o_byte_valid = byte_valid;
    assign o_cs_active  = ~cs_sync_q;

endmodule

// File: rtl/spi_pixel_writer.sv
// SPI command decoder driving the pixel RAM write port: streamed pixel writes
// with auto-increment and a whole-RAM fill.
module spi_pixel_writer
    import panel_pkg::*;
#(
    parameter int         ADDR_WIDTH = PIX_ADDR_WIDTH,
    parameter int         DATA_WIDTH = PIX_DATA_WIDTH,
    parameter logic [7:0] CMD_WRITE  = OP_WRITE,
    parameter logic [7:0] CMD_FILL   = OP_FILL
) (
    input  logic              i_clk,
    input  logic              i_reset,
    spi_pixel_writer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       cs_active;

    spi_byte_rx u_rx (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_spi_sck    (bus.i_spi_sck),
        .i_spi_mosi   (bus.i_spi_mosi),
        .i_spi_cs_n   (bus.i_spi_cs_n),
        .o_byte       (rx_byte),
        .o_byte_valid (rx_valid),
        .o_cs_active  (cs_active)
    );

    state_t                state_q, state_d;
    logic                  is_fill_q, is_fill_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_hi_q, data_hi_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  w_en_q, w_en_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  wrote_q, wrote_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                  fill_last_q, fill_last_d;
    logic                  cs_prev_q;
    logic                  cs_rise, cs_fall, bv;

    assign cs_rise = cs_prev_q & ~cs_active;
    assign cs_fall = ~cs_prev_q & cs_active;
    // A chip-select rise beats a byte completing in the same cycle.
    assign bv      = rx_valid & ~cs_rise;

    always_comb begin
        state_d      = state_q;
        is_fill_d    = is_fill_q;
        addr_d       = addr_q;
        data_hi_d    = data_hi_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_en_d       = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = fill_last_q;
        wrote_d      = wrote_q;
        fill_cnt_d   = fill_cnt_q;
        fill_last_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    wrote_d = 1'b0;
                end
            end
            ST_CMD: begin
                if (bv) begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_FILL) begin
                        is_fill_d = (rx_byte == CMD_FILL);
                        state_d   = ST_ADDR_HI;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
            end
            ST_ADDR_HI: begin
                if (bv) begin
                    addr_d  = {rx_byte[ADDR_WIDTH-9:0], addr_q[7:0]};
                    state_d = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (bv) begin
                    addr_d  = {addr_q[ADDR_WIDTH-1:8], rx_byte};
                    state_d = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                if (bv) begin
                    data_hi_d = rx_byte;
                    state_d   = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                if (bv) begin
                    w_data_d = {data_hi_q, rx_byte};
                    if (is_fill_q) begin
                        fill_cnt_d = '0;
                        state_d    = ST_FILL;
                    end else begin
                        w_en_d   = 1'b1;
                        w_addr_d = addr_q;
                        addr_d   = addr_q + ADDR_ONE;
                        wrote_d  = 1'b1;
                        state_d  = ST_PIX_HI;
                    end
                end
            end
            ST_FILL: begin
                w_en_d     = 1'b1;
                busy_d     = 1'b1;
                w_addr_d   = fill_cnt_q;
                fill_cnt_d = fill_cnt_q + ADDR_ONE;
                if (fill_cnt_q == ADDR_MAX) begin
                    fill_last_d = 1'b1;
                    state_d     = cs_active ? ST_IGNORE : ST_IDLE;
                end
            end
            ST_IGNORE: begin
                state_d = ST_IGNORE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fill runs to completion regardless of chip select.
        if (cs_rise && state_q != ST_FILL && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            wrote_d = 1'b0;
            if (wrote_q) begin
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            is_fill_q    <= 1'b0;
            addr_q       <= '0;
            data_hi_q    <= 8'd0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wrote_q      <= 1'b0;
            fill_cnt_q   <= '0;
            fill_last_q  <= 1'b0;
            cs_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_fill_q    <= is_fill_d;
            addr_q       <= addr_d;
            data_hi_q    <= data_hi_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_en_q       <= w_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            wrote_q      <= wrote_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_last_q  <= fill_last_d;
            cs_prev_q    <= cs_active;
        end
    end

    assign bus.o_ram_w_addr   = w_addr_q;
    assign bus.o_ram_w_data   = w_data_q;
    assign bus.o_ram_w_enable = w_en_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_frame_done   = frame_done_q;
    assign bus.o_dbg_state    = state_q;

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Directed bench for spi_pixel_writer: expected RAM writes go into a queue
// that a negedge monitor drains; frame/busy events are counted alongside.
module tb_spi_pixel_writer;
    import panel_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_pixel_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_pixel_writer dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [AW+DW-1:0] exp_q[$];
    int vectors = 0;
    int errors = 0;
    int fd_count = 0;
    int busy_cycles = 0;
    logic fd_after_fill = 1'b0;
    logic prev_en = 1'b0;
    logic prev_busy = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.o_ram_w_enable) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%03h data=%04h, required none",
                         bus.o_ram_w_addr, bus.o_ram_w_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({bus.o_ram_w_addr, bus.o_ram_w_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%03h data=%04h, required addr=%03h data=%04h",
                             bus.o_ram_w_addr, bus.o_ram_w_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (bus.o_busy) busy_cycles++;
        if (bus.o_frame_done) begin
            fd_count++;
            fd_after_fill = prev_en & prev_busy & (prev_addr == 12'hFFF);
        end
        prev_en   = bus.o_ram_w_enable;
        prev_busy = bus.o_busy;
        prev_addr = bus.o_ram_w_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.i_spi_mosi = b[i];
            #40 bus.i_spi_sck = 1'b1;
            #40 bus.i_spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        bus.i_spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80 bus.i_spi_cs_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(posedge clk);
    endtask

    int fd_base;

    initial begin
        bus.i_spi_sck  = 1'b0;
        bus.i_spi_mosi = 1'b0;
        bus.i_spi_cs_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_addr",  32'(bus.o_ram_w_addr), 32'h0);
        check("rst_data",  32'(bus.o_ram_w_data), 32'h0);
        check("rst_en",    32'(bus.o_ram_w_enable), 32'h0);
        check("rst_busy",  32'(bus.o_busy), 32'h0);
        check("rst_fd",    32'(bus.o_frame_done), 32'h0);
        check("rst_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));

        // Streamed write of two words
        fd_base = fd_count;
        expect_write(12'h010, 16'hABCD);
        expect_write(12'h011, 16'h1234);
        cs_begin();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h10);
        spi_byte(8'hAB); spi_byte(8'hCD); spi_byte(8'h12); spi_byte(8'h34);
        cs_end();
        drain("basic");
        check("basic_frame_done", 32'(fd_count - fd_base), 32'd1);

        // Address wrap 0xFFF -> 0x000
        fd_base = fd_count;
        expect_write(12'hFFF, 16'h1111);
        expect_write(12'h000, 16'h2222);
        cs_begin();
        spi_byte(8'h01); spi_byte(8'h0F); spi_byte(8'hFF);
        spi_byte(8'h11); spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h22);
        cs_end();
        drain("wrap");
        check("wrap_frame_done", 32'(fd_count - fd_base), 32'd1);

        // Whole-RAM fill; the supplied address is ignored
        fd_base = fd_count;
        busy_cycles = 0;
        fd_after_fill = 1'b0;
        for (int a = 0; a < 4096; a++) expect_write(a[AW-1:0], 16'hF00F);
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'h45);
        spi_byte(8'hF0); spi_byte(8'h0F);
        cs_end();
        drain("fill");
        check("fill_busy_cycles", 32'(busy_cycles), 32'd4096);
        check("fill_frame_done", 32'(fd_count - fd_base), 32'd1);
        check("fill_done_timing", 32'(fd_after_fill), 32'd1);
        check("fill_busy_low", 32'(bus.o_busy), 32'd0);

        // Half pixel then CS rise mid-byte: nothing written
        fd_base = fd_count;
        cs_begin();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'hAB);
        spi_bits(8'hCD, 4);
        cs_end();
        drain("partial");
        check("partial_frame_done", 32'(fd_count - fd_base), 32'd0);

        // Unknown opcode ignored, then a good write
        fd_base = fd_count;
        cs_begin();
        spi_byte(8'h7E);
        for (int i = 0; i < 6; i++) spi_byte(8'h01);
        cs_end();
        check("ignore_frame_done", 32'(fd_count - fd_base), 32'd0);
        expect_write(12'h234, 16'h5AA5);
        cs_begin();
        spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h34);
        spi_byte(8'h5A); spi_byte(8'hA5);
        cs_end();
        drain("after_ignore");
        check("after_ignore_frame_done", 32'(fd_count - fd_base), 32'd1);

        // Reset in the middle of a fill
        fd_base = fd_count;
        for (int a = 0; a < 4096; a++) expect_write(a[AW-1:0], 16'h1234);
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00);
        spi_byte(8'h12); spi_byte(8'h34);
        cs_end();
        for (int i = 0; i < 200 && !bus.o_busy; i++) @(posedge clk);
        check("reset_fill_started", 32'(bus.o_busy), 32'd1);
        repeat (100) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("reset_en",   32'(bus.o_ram_w_enable), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_addr", 32'(bus.o_ram_w_addr), 32'd0);
        check("reset_data", 32'(bus.o_ram_w_data), 32'd0);
        check("reset_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        expect_write(12'h777, 16'hBEEF);
        cs_begin();
        spi_byte(8'h01); spi_byte(8'h07); spi_byte(8'h77);
        spi_byte(8'hBE); spi_byte(8'hEF);
        cs_end();
        drain("after_reset");
        check("after_reset_frame_done", 32'(fd_count - fd_base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
